// File: rtl/caravel_uart_master_pkg.sv
// Shared command/reply codes and controller state encoding for the UART-to-Wishbone bridge.
package caravel_uart_master_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] RSP_ACK    = 8'h06;
  localparam logic [7:0] RSP_NAK    = 8'h15;
  localparam logic [7:0] RSP_PROMPT = 8'h3E;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADR,
    GET_DAT,
    WB_REQ,
    RESP,
    SEND
  } state_t;

endpackage

// File: rtl/caravel_uart_master_uart_core.sv
// 8N1 receiver (16x oversampled, mid-bit sampling) and 8N2 transmitter sharing one baud divisor.
module uart_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] baud_div,
  input  logic        rxd,
  output logic        txd,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        tick,
  input  logic [7:0]  tx_byte,
  input  logic        tx_start,
  output logic        tx_busy
);

  logic [11:0] div_cnt;
  logic        rx_on;
  logic [3:0]  rx_tc;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic [10:0] tx_sh;
  logic [3:0]  tx_left;
  logic [11:0] tx_div;
  logic [3:0]  tx_tc;

  // >= so a divisor lowered while the counter is above it does not stall for a full wrap
  assign tick     = (div_cnt >= baud_div);
  assign rx_byte  = rx_sh;
  assign rx_busy  = rx_on;
  assign txd      = tx_sh[0];
  assign tx_busy  = (tx_left != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_on    <= 1'b0;
      rx_tc    <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_on) begin
        if (!rxd) begin
          rx_on  <= 1'b1;
          rx_tc  <= '0;
          rx_bit <= '0;
        end
      end else if (tick) begin
        rx_tc <= rx_tc + 4'd1;
        if (rx_bit == 4'd0 && rx_tc == 4'd7) begin
          // start bit re-checked at its middle; a high level here was a glitch
          if (rxd) rx_on <= 1'b0;
          else begin
            rx_bit <= 4'd1;
            rx_tc  <= '0;
          end
        end else if (rx_bit != 4'd0 && rx_tc == 4'd15) begin
          rx_tc <= '0;
          if (rx_bit <= 4'd8) begin
            rx_sh  <= {rxd, rx_sh[7:1]};
            rx_bit <= rx_bit + 4'd1;
          end else begin
            rx_on    <= 1'b0;
            rx_valid <= rxd;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh   <= '1;
      tx_left <= '0;
      tx_div  <= '0;
      tx_tc   <= '0;
    end else if (tx_start && !tx_busy) begin
      tx_sh   <= {2'b11, tx_byte, 1'b0};
      tx_left <= 4'd11;
      tx_div  <= '0;
      tx_tc   <= '0;
    end else if (tx_busy) begin
      if (tx_div >= baud_div) begin
        tx_div <= '0;
        tx_tc  <= tx_tc + 4'd1;
        if (tx_tc == 4'd15) begin
          tx_sh   <= {1'b1, tx_sh[10:1]};
          tx_left <= tx_left - 4'd1;
        end
      end else begin
        tx_div <= tx_div + 12'd1;
      end
    end
  end

endmodule

// File: rtl/caravel_uart_master.sv
// UART command bridge: parses write/read commands from a host and runs single Wishbone cycles.
module caravel_uart_master
  import caravel_uart_master_pkg::*;
#(
  parameter int unsigned WB_TMO = 256,
  parameter int unsigned RX_TMO = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [11:0] cfg_baud_div,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  logic [7:0]  rx_byte, tx_byte;
  logic        rx_valid, rx_busy, tick, tx_start, tx_busy;
  state_t      state, next;
  logic        prompt, cmd_we, ok;
  logic [1:0]  byte_cnt;
  logic [31:0] sh, adr_q, rdata;
  logic [39:0] resp_buf;
  logic [2:0]  resp_cnt;
  logic [15:0] rx_gap, wb_cnt;
  logic        rx_tmo, wb_tmo, wb_done, last_byte;

  uart_core u_core (
    .clk(wb_clk_i), .rst(wb_rst_i), .baud_div(cfg_baud_div),
    .rxd(uart_rxd), .txd(uart_txd),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_busy(rx_busy), .tick(tick),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always_comb begin
    rx_tmo    = (rx_gap == 16'(RX_TMO * 16));
    wb_tmo    = (wb_cnt == 16'(WB_TMO - 1));
    wb_done   = wbm_ack_i | wbm_err_i | wb_tmo;
    last_byte = rx_valid && (byte_cnt == 2'd3);
    tx_start  = (state == SEND) && (resp_cnt != 3'd0) && !tx_busy;
    tx_byte   = resp_buf[39:32];
    next      = state;
    case (state)
      IDLE:    if (prompt) next = SEND;
               else if (rx_valid)
                 next = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? GET_ADR : SEND;
      GET_ADR: if (rx_tmo) next = IDLE;
               else if (last_byte) next = cmd_we ? GET_DAT : WB_REQ;
      GET_DAT: if (rx_tmo) next = IDLE;
               else if (last_byte) next = WB_REQ;
      WB_REQ:  if (wb_done) next = RESP;
      RESP:    next = SEND;
      SEND:    if (resp_cnt == 3'd0 && !tx_busy) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else state <= next;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prompt    <= 1'b1;
      cmd_we    <= 1'b0;
      ok        <= 1'b0;
      byte_cnt  <= '0;
      sh        <= '0;
      adr_q     <= '0;
      rdata     <= '0;
      resp_buf  <= '0;
      resp_cnt  <= '0;
      rx_gap    <= '0;
      wb_cnt    <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      // idle line time is measured only between bytes, never while a frame is arriving
      if ((state == GET_ADR || state == GET_DAT) && !rx_busy && !rx_valid) begin
        if (tick) rx_gap <= rx_gap + 16'd1;
      end else begin
        rx_gap <= '0;
      end
      case (state)
        IDLE: begin
          if (prompt) begin
            resp_buf <= {RSP_PROMPT, 32'h0};
            resp_cnt <= 3'd1;
            prompt   <= 1'b0;
          end else if (rx_valid) begin
            byte_cnt <= '0;
            cmd_we   <= (rx_byte == CMD_WRITE);
            resp_buf <= {RSP_NAK, 32'h0};
            resp_cnt <= 3'd1;
          end
        end
        GET_ADR, GET_DAT: begin
          if (rx_valid && !rx_tmo) begin
            sh       <= {sh[23:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte && state == GET_ADR) adr_q <= {sh[23:0], rx_byte};
          end
          if (next == WB_REQ) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_sel_o <= 4'hF;
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= (state == GET_ADR) ? {sh[23:0], rx_byte} : adr_q;
            wbm_dat_o <= cmd_we ? {sh[23:0], rx_byte} : '0;
            wb_cnt    <= '0;
          end
        end
        WB_REQ: begin
          wb_cnt <= wb_cnt + 16'd1;
          if (wb_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            ok        <= wbm_ack_i && !wbm_err_i;
            rdata     <= wbm_dat_i;
          end
        end
        RESP: begin
          if (ok) begin
            resp_buf <= {RSP_ACK, rdata};
            resp_cnt <= cmd_we ? 3'd1 : 3'd5;
          end else begin
            resp_buf <= {RSP_NAK, 32'h0};
            resp_cnt <= 3'd1;
          end
        end
        SEND: begin
          if (tx_start) begin
            resp_buf <= {resp_buf[31:0], 8'h0};
            resp_cnt <= resp_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_caravel_uart_master.sv
// Directed bench: drives host UART frames, models a Wishbone slave, decodes reply frames.
module tb_caravel_uart_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [11:0] cfg_baud_div = 12'd15;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  caravel_uart_master #(.WB_TMO(256), .RX_TMO(64)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_baud_div(cfg_baud_div),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int bt = 256;
  logic [7:0] cmd_buf [9];
  logic [7:0] rep_buf [5];

  // slave_mode: 0 ack, 1 err, 2 never respond, 3 ack and err together
  int slave_mode = 0;
  int slave_delay = 2;
  int wb_cycles = 0;
  logic [31:0] mem [64];
  logic [31:0] last_adr = '0, last_dat = '0;
  logic [3:0]  last_sel = '0;
  logic        last_we = 1'b0;

  initial begin : slave
    int cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o && !prev) wb_cycles++;
      prev = wbm_cyc_o;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
        cnt++;
        if (slave_mode != 2 && cnt == slave_delay) begin
          last_adr = wbm_adr_o;
          last_dat = wbm_dat_o;
          last_sel = wbm_sel_o;
          last_we  = wbm_we_o;
          if (wbm_we_o) mem[wbm_adr_o[7:2]] = wbm_dat_o;
          else wbm_dat_i = mem[wbm_adr_o[7:2]];
          wbm_ack_i = (slave_mode == 0 || slave_mode == 3);
          wbm_err_i = (slave_mode == 1 || slave_mode == 3);
        end
      end else begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach its end within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      uart_rxd = 1'b0;
      repeat (bt) @(negedge wb_clk_i);
      for (int j = 0; j < 8; j++) begin
        uart_rxd = cmd_buf[i][j];
        repeat (bt) @(negedge wb_clk_i);
      end
      uart_rxd = 1'b1;
      repeat (bt) @(negedge wb_clk_i);
    end
  endtask

  task automatic recv_byte(input int limit, output logic [7:0] b, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    b = '0;
    while (uart_txd !== 1'b0 && t < limit) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (uart_txd !== 1'b0) return;
    repeat (bt / 2) @(negedge wb_clk_i);
    if (uart_txd !== 1'b0) return;
    for (int j = 0; j < 8; j++) begin
      repeat (bt) @(negedge wb_clk_i);
      b[j] = uart_txd;
    end
    repeat (bt) @(negedge wb_clk_i);
    ok = (uart_txd === 1'b1);
  endtask

  task automatic get_reply(input int nrep, input int ncmd, output int got);
    logic [7:0] b;
    bit ok;
    got = 0;
    for (int k = 0; k < nrep; k++) begin
      recv_byte((k == 0) ? (ncmd * 10 + 4) * bt + 600 : 14 * bt, b, ok);
      if (!ok) break;
      rep_buf[k] = b;
      got++;
    end
  endtask

  task automatic xact(input int ncmd, input int nrep, output int got);
    int g;
    g = 0;
    fork
      send_bytes(ncmd);
      get_reply(nrep, ncmd, g);
    join
    got = g;
  endtask

  task automatic load_write(input logic [31:0] adr, input logic [31:0] dat);
    cmd_buf[0] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      cmd_buf[1 + i] = adr[31 - 8 * i -: 8];
      cmd_buf[5 + i] = dat[31 - 8 * i -: 8];
    end
  endtask

  task automatic load_read(input logic [31:0] adr);
    cmd_buf[0] = 8'h02;
    for (int i = 0; i < 4; i++) cmd_buf[1 + i] = adr[31 - 8 * i -: 8];
  endtask

  task automatic test_reset;
    int lat, run;
    repeat (4) @(negedge wb_clk_i);
    n_cmp++;
    if ({uart_txd, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctl: got txd/cyc/stb/we %b want 1000", {uart_txd, wbm_cyc_o, wbm_stb_o, wbm_we_o});
    end
    n_cmp++;
    if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got adr %h dat %h sel %h want zeros", wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    wb_rst_i = 1'b0;
    lat = 0;
    while (uart_txd !== 1'b0 && lat < 20) begin
      @(negedge wb_clk_i);
      lat++;
    end
    n_cmp++;
    if (lat < 1 || lat > 4) begin
      n_bad++;
      $display("FAIL prompt_latency: got %0d clocks want 1..4", lat);
    end
    // 0x3E LSB first after start: low 2 bits, high 5 bits, low 2 bits, then stop
    run = 0;
    while (uart_txd === 1'b0 && run < 4000) begin @(negedge wb_clk_i); run++; end
    n_cmp++;
    if (run != 512) begin n_bad++; $display("FAIL prompt_low1: got %0d clocks want 512", run); end
    run = 0;
    while (uart_txd === 1'b1 && run < 4000) begin @(negedge wb_clk_i); run++; end
    n_cmp++;
    if (run != 1280) begin n_bad++; $display("FAIL prompt_high: got %0d clocks want 1280", run); end
    run = 0;
    while (uart_txd === 1'b0 && run < 4000) begin @(negedge wb_clk_i); run++; end
    n_cmp++;
    if (run != 512) begin n_bad++; $display("FAIL prompt_low2: got %0d clocks want 512", run); end
    run = 0;
    while (uart_txd === 1'b1 && run < 4096) begin @(negedge wb_clk_i); run++; end
    n_cmp++;
    if (run != 4096) begin n_bad++; $display("FAIL prompt_idle: line low after %0d clocks want high 4096", run); end
  endtask

  task automatic test_write;
    int got, c0;
    c0 = wb_cycles;
    slave_mode = 0;
    slave_delay = 2;
    load_write(32'h30020058, 32'h11223344);
    xact(9, 1, got);
    n_cmp++;
    if (got != 1 || rep_buf[0] !== 8'h06) begin
      n_bad++;
      $display("FAIL write_reply: got %0d bytes first %h want 1 byte 06", got, rep_buf[0]);
    end
    n_cmp++;
    if (wb_cycles - c0 != 1) begin n_bad++; $display("FAIL write_cycles: got %0d want 1", wb_cycles - c0); end
    n_cmp++;
    if (last_adr !== 32'h30020058 || last_dat !== 32'h11223344) begin
      n_bad++;
      $display("FAIL write_bus: got adr %h dat %h want 30020058 11223344", last_adr, last_dat);
    end
    n_cmp++;
    if (last_sel !== 4'hF || last_we !== 1'b1) begin
      n_bad++;
      $display("FAIL write_sel_we: got sel %h we %b want f 1", last_sel, last_we);
    end
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      n_bad++;
      $display("FAIL write_idle: got cyc %b stb %b want 0 0", wbm_cyc_o, wbm_stb_o);
    end
  endtask

  task automatic test_readback;
    logic [31:0] words [6];
    logic [31:0] rd;
    int got;
    words = '{32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677, 32'h55667788, 32'h66778899};
    slave_mode = 0;
    for (int i = 0; i < 6; i++) begin
      load_write(32'h30020058 + 32'(4 * i), words[i]);
      xact(9, 1, got);
      n_cmp++;
      if (got != 1 || rep_buf[0] !== 8'h06) begin
        n_bad++;
        $display("FAIL rb_write%0d: got %0d bytes first %h want 1 byte 06", i, got, rep_buf[0]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      load_read(32'h30020058 + 32'(4 * i));
      xact(5, 5, got);
      rd = {rep_buf[1], rep_buf[2], rep_buf[3], rep_buf[4]};
      n_cmp++;
      if (got != 5 || rep_buf[0] !== 8'h06 || rd !== words[i]) begin
        n_bad++;
        $display("FAIL rb_read%0d: got %0d bytes %h data %h want 5 bytes 06 data %h", i, got, rep_buf[0], rd, words[i]);
      end
    end
  endtask

  task automatic test_wb_fail(input int mode);
    int got;
    slave_mode = mode;
    load_read(32'h30020058);
    xact(5, 2, got);
    n_cmp++;
    if (got != 1 || rep_buf[0] !== 8'h15) begin
      n_bad++;
      $display("FAIL wb_fail_mode%0d: got %0d bytes first %h want 1 byte 15", mode, got, rep_buf[0]);
    end
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_fail_idle%0d: got cyc %b stb %b want 0 0", mode, wbm_cyc_o, wbm_stb_o);
    end
    slave_mode = 0;
  endtask

  task automatic test_bad_cmd;
    int got, c0;
    c0 = wb_cycles;
    cmd_buf[0] = 8'h7F;
    xact(1, 2, got);
    n_cmp++;
    if (got != 1 || rep_buf[0] !== 8'h15) begin
      n_bad++;
      $display("FAIL bad_cmd: got %0d bytes first %h want 1 byte 15", got, rep_buf[0]);
    end
    n_cmp++;
    if (wb_cycles != c0) begin n_bad++; $display("FAIL bad_cmd_cycles: got %0d want 0", wb_cycles - c0); end
  endtask

  task automatic test_rx_timeout;
    logic [7:0] b;
    bit ok;
    int got;
    load_write(32'h30020000, 32'hDEADBEEF);
    send_bytes(4);
    recv_byte(80 * bt, b, ok);
    n_cmp++;
    if (ok) begin n_bad++; $display("FAIL rx_tmo_silent: got byte %h want no reply", b); end
    load_read(32'h30020058);
    xact(5, 5, got);
    n_cmp++;
    if (got != 5 || rep_buf[0] !== 8'h06 || {rep_buf[1], rep_buf[2], rep_buf[3], rep_buf[4]} !== 32'h11223344) begin
      n_bad++;
      $display("FAIL rx_tmo_next: got %0d bytes %h %h%h%h%h want 06 11223344", got,
               rep_buf[0], rep_buf[1], rep_buf[2], rep_buf[3], rep_buf[4]);
    end
  endtask

  task automatic test_reset_mid_wb;
    logic [7:0] b;
    bit ok;
    int t;
    slave_mode = 2;
    load_read(32'h30020058);
    send_bytes(5);
    t = 0;
    while (wbm_cyc_o !== 1'b1 && t < 100) begin @(negedge wb_clk_i); t++; end
    n_cmp++;
    if (wbm_cyc_o !== 1'b1) begin n_bad++; $display("FAIL mid_wb_start: got cyc %b want 1", wbm_cyc_o); end
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_wb_abort: got cyc %b stb %b want 0 0", wbm_cyc_o, wbm_stb_o);
    end
    repeat (3) @(negedge wb_clk_i);
    slave_mode = 0;
    wb_rst_i = 1'b0;
    recv_byte(40 * bt, b, ok);
    n_cmp++;
    if (!ok || b !== 8'h3E) begin n_bad++; $display("FAIL mid_wb_prompt: got ok %b byte %h want 3e", ok, b); end
  endtask

  initial begin
    test_reset;
    cfg_baud_div = 12'd1;
    bt = 32;
    repeat (10) @(negedge wb_clk_i);
    test_write;
    test_readback;
    test_wb_fail(1);
    test_wb_fail(2);
    test_wb_fail(3);
    test_bad_cmd;
    test_rx_timeout;
    test_reset_mid_wb;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/caravel_uart_master.md
CARAVEL_UART_MASTER -- requirements
Module: caravel_uart_master

Interface
REQ-001 Parameter WB_TMO, default 256: Wishbone cycles to wait for ack/err before abort.
REQ-002 Parameter RX_TMO, default 64: idle bit-times allowed between bytes of one command.
REQ-003 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 cfg_baud_div  in  12  baud divisor N; bit-time = 16*(N+1) clocks.
REQ-006 uart_rxd  in  1  serial input from host, idle high, already synchronised.
REQ-007 uart_txd  out  1  serial output to host, idle high.
REQ-008 wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone classic cycle/strobe.
REQ-009 wbm_we_o  out  1  1 = write.
REQ-010 wbm_adr_o  out  32  byte address.
REQ-011 wbm_dat_o  out  32  write data.
REQ-012 wbm_sel_o  out  4  byte enables, always 4'hF during a cycle.
REQ-013 wbm_dat_i  in  32  read data.
REQ-014 wbm_ack_i, wbm_err_i  in  1 each  cycle termination.

Function
REQ-015 UART frame 8 data bits, LSB first, no parity; TX sends 2 stop bits, RX accepts 1 or more.
REQ-016 RX samples at 16x oversample, mid-bit (tick 8); start bit re-checked at mid-bit, low-glitch ignored; stop bit low = framing error, byte dropped.
REQ-017 One clock after reset deassertion, TX sends prompt byte 8'h3E ('>') once.
REQ-018 Command byte 8'h01 = write: followed by 4 address bytes then 4 data bytes, MSB first.
REQ-019 Command byte 8'h02 = read: followed by 4 address bytes, MSB first.
REQ-020 Any other command byte: reply 8'h15 (NAK), return to IDLE.
REQ-021 FSM states: IDLE, GET_ADR, GET_DAT, WB_REQ, RESP, SEND; GET_DAT only for write.
REQ-022 WB_REQ: cyc/stb/sel/we/adr/dat driven in the cycle after last byte received; held until ack_i or err_i seen; cyc/stb deasserted the following cycle.
REQ-023 On ack: write replies 8'h06; read replies 8'h06 then 4 bytes of captured wbm_dat_i, MSB first.
REQ-024 On err_i, or WB_TMO cycles without ack/err: terminate cycle, reply 8'h15 only (no data bytes).
REQ-025 ack_i and err_i in the same cycle: err wins.
REQ-026 Inter-byte gap > RX_TMO bit-times inside GET_ADR/GET_DAT: discard partial command, return IDLE silently.
REQ-027 Bytes received while in WB_REQ/RESP/SEND are dropped; host must wait for the full reply.
REQ-028 TX back-to-back bytes of a reply with no idle gap beyond the stop bits.
REQ-029 cfg_baud_div sampled continuously; changing it mid-frame is undefined, not guarded.

Reset
REQ-030 wb_rst_i high: FSM IDLE, uart_txd=1, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=wbm_dat_o=0, wbm_sel_o=0, shift registers/counters cleared.
REQ-031 Reset mid-command or mid-Wishbone-cycle aborts immediately; cycle dropped, no reply; prompt resent after release.

Structure
REQ-032 Shared package caravel_uart_master_pkg holds command codes (01, 02), reply codes (06, 15, 3E) and FSM state enum.
REQ-033 One sub-module uart_core: baud tick generator, RX and TX; exposes rx_byte/rx_valid and tx_byte/tx_start/tx_busy.
REQ-034 Command parser, Wishbone master and reply sequencer live in the top module.

Verification
REQ-035 Reset release, N=15 -> exactly one byte 8'h3E on uart_txd at bit-time 256 clocks, then idle high.
REQ-036 Write 01 30 02 00 58 11 22 33 44, slave acks after 2 cycles -> one WB write adr 32'h30020058, dat 32'h11223344, sel F; reply 06.
REQ-037 Write six words 0x30020058..0x3002006C (11223344..66778899), read each back with 02+addr -> replies 06 + matching 4 bytes MSB first.
REQ-038 Read with slave asserting err_i, and separately with no ack for 256 cycles -> reply 15 only, cyc/stb low afterwards.
REQ-039 Command byte 8'h7F -> reply 15, no WB cycle; command 01 plus 3 bytes then silence > 64 bit-times -> no reply, next valid command works.
REQ-040 Assert wb_rst_i while wbm_cyc_o=1 -> cyc/stb low next clock, prompt 3E after release.
